// File: rtl/fft_seq_pkg.sv
// rtl/fft_seq_pkg.sv - shared state encoding and parameter defaults for the FFT frame sequencer
package fft_seq_pkg;

    localparam int          FFT_LEN_DEFAULT  = 1024;
    localparam int          CNT_W_DEFAULT    = 10;
    localparam logic [15:0] CFG_WORD_DEFAULT = 16'h0001;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CONFIG = 3'd1,
        ST_LOAD   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } seq_state_t;

endpackage

// File: rtl/axis_reg_slice32.sv
// rtl/axis_reg_slice32.sv - single-stage register slice carrying 32-bit data, a bin index and last
module axis_reg_slice32 #(
    parameter int IDX_W = 10
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             clear,
    input  logic [31:0]      s_tdata,
    input  logic [IDX_W-1:0] s_index,
    input  logic             s_tlast,
    input  logic             s_tvalid,
    output logic             s_tready,
    output logic [31:0]      m_tdata,
    output logic [IDX_W-1:0] m_index,
    output logic             m_tlast,
    output logic             m_tvalid,
    input  logic             m_tready
);

    // Accept a new word whenever the slot is empty or is being emptied this cycle.
    assign s_tready = !m_tvalid || m_tready;

    // Capture on input handshake; payload only moves on capture so it holds under stall.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
            m_index  <= '0;
            m_tlast  <= 1'b0;
        end else if (clear) begin
            m_tvalid <= 1'b0;
        end else if (s_tvalid && s_tready) begin
            m_tvalid <= 1'b1;
            m_tdata  <= s_tdata;
            m_index  <= s_index;
            m_tlast  <= s_tlast;
        end else if (m_tready) begin
            m_tvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/fft_frame_sequencer.sv
// rtl/fft_frame_sequencer.sv - sequences one FFT frame: config, sample load, indexed magnitude drain
module fft_frame_sequencer
    import fft_seq_pkg::*;
#(
    parameter int          FFT_LEN  = FFT_LEN_DEFAULT,
    parameter int          CNT_W    = CNT_W_DEFAULT,
    parameter logic [15:0] CFG_WORD = CFG_WORD_DEFAULT
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             start,
    input  logic             abort,
    output logic [15:0]      cfg_tdata,
    output logic             cfg_tvalid,
    input  logic             cfg_tready,
    input  logic [31:0]      src_tdata,
    input  logic             src_tvalid,
    output logic             src_tready,
    output logic [63:0]      fft_tdata,
    output logic             fft_tvalid,
    input  logic             fft_tready,
    output logic             fft_tlast,
    input  logic [31:0]      mag_tdata,
    input  logic             mag_tvalid,
    output logic             mag_tready,
    output logic [31:0]      bin_tdata,
    output logic [CNT_W-1:0] bin_index,
    output logic             bin_tvalid,
    input  logic             bin_tready,
    output logic             bin_tlast,
    output logic             busy,
    output logic             frame_done
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FFT_LEN - 1);

    seq_state_t       state;
    seq_state_t       state_next;
    logic [CNT_W-1:0] in_cnt;
    logic [CNT_W-1:0] out_cnt;
    logic             mag_en;
    logic             slice_ready;
    logic             abort_act;
    logic             flush;
    logic             fft_hs;
    logic             mag_hs;
    logic             bin_last_hs;

    assign abort_act   = abort && (state != ST_IDLE);
    assign fft_hs      = fft_tvalid && fft_tready;
    assign mag_hs      = mag_tvalid && mag_tready;
    assign bin_last_hs = bin_tvalid && bin_tready && bin_tlast;
    assign mag_tready  = mag_en && slice_ready;
    // A word slipping in alongside the final bin handshake belongs to no frame, so DONE drops it too.
    assign flush       = abort_act || (state == ST_DONE);

    // State register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; abort overrides every other transition outside IDLE.
    always_comb begin
        state_next = state;
        if (abort_act) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   if (start)                state_next = ST_CONFIG;
                ST_CONFIG: if (cfg_tready)           state_next = ST_LOAD;
                ST_LOAD:   if (fft_hs && fft_tlast)  state_next = ST_DRAIN;
                ST_DRAIN:  if (bin_last_hs)          state_next = ST_DONE;
                ST_DONE:                             state_next = ST_IDLE;
                default:                             state_next = ST_IDLE;
            endcase
        end
    end

    // Per-state outputs; LOAD is a zero-latency pass from the sample source to the FFT input.
    always_comb begin
        cfg_tvalid = 1'b0;
        cfg_tdata  = '0;
        src_tready = 1'b0;
        fft_tvalid = 1'b0;
        fft_tlast  = 1'b0;
        fft_tdata  = {32'h0, src_tdata};
        mag_en     = 1'b0;
        busy       = 1'b1;
        frame_done = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
            end
            ST_CONFIG: begin
                cfg_tvalid = 1'b1;
                cfg_tdata  = CFG_WORD;
            end
            ST_LOAD: begin
                src_tready = fft_tready;
                fft_tvalid = src_tvalid;
                fft_tlast  = (in_cnt == LAST_IDX);
                mag_en     = 1'b1;
            end
            ST_DRAIN: begin
                mag_en = 1'b1;
            end
            ST_DONE: begin
                frame_done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Sample and bin counters; both restart at the terminal index so a frame never wraps mid-way.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            in_cnt  <= '0;
            out_cnt <= '0;
        end else if (flush) begin
            in_cnt  <= '0;
            out_cnt <= '0;
        end else begin
            if (fft_hs) begin
                in_cnt <= fft_tlast ? '0 : in_cnt + CNT_W'(1);
            end
            if (mag_hs) begin
                out_cnt <= (out_cnt == LAST_IDX) ? '0 : out_cnt + CNT_W'(1);
            end
        end
    end

    axis_reg_slice32 #(
        .IDX_W (CNT_W)
    ) u_bin_slice (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .clear    (flush),
        .s_tdata  (mag_tdata),
        .s_index  (out_cnt),
        .s_tlast  (out_cnt == LAST_IDX),
        .s_tvalid (mag_tvalid && mag_en),
        .s_tready (slice_ready),
        .m_tdata  (bin_tdata),
        .m_index  (bin_index),
        .m_tlast  (bin_tlast),
        .m_tvalid (bin_tvalid),
        .m_tready (bin_tready)
    );

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// tb/tb_fft_frame_sequencer.sv - scoreboard bench for fft_frame_sequencer at FFT_LEN=8
module tb_fft_frame_sequencer;

    localparam int FFT_LEN = 8;
    localparam int CNT_W   = 3;

    logic             aclk       = 1'b0;
    logic             aresetn    = 1'b0;
    logic             start      = 1'b0;
    logic             abort      = 1'b0;
    logic [15:0]      cfg_tdata;
    logic             cfg_tvalid;
    logic             cfg_tready = 1'b0;
    logic [31:0]      src_tdata  = 32'h0;
    logic             src_tvalid = 1'b0;
    logic             src_tready;
    logic [63:0]      fft_tdata;
    logic             fft_tvalid;
    logic             fft_tready = 1'b0;
    logic             fft_tlast;
    logic [31:0]      mag_tdata  = 32'h0;
    logic             mag_tvalid = 1'b0;
    logic             mag_tready;
    logic [31:0]      bin_tdata;
    logic [CNT_W-1:0] bin_index;
    logic             bin_tvalid;
    logic             bin_tready = 1'b0;
    logic             bin_tlast;
    logic             busy;
    logic             frame_done;

    int checks      = 0;
    int failures    = 0;
    int done_pulses = 0;

    logic [64:0] fft_q[$];
    logic [35:0] bin_q[$];

    logic [31:0] samples [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                                 32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};

    logic        held_v = 1'b0;
    logic [35:0] held   = '0;

    fft_frame_sequencer #(
        .FFT_LEN  (FFT_LEN),
        .CNT_W    (CNT_W),
        .CFG_WORD (16'h0001)
    ) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .start      (start),
        .abort      (abort),
        .cfg_tdata  (cfg_tdata),
        .cfg_tvalid (cfg_tvalid),
        .cfg_tready (cfg_tready),
        .src_tdata  (src_tdata),
        .src_tvalid (src_tvalid),
        .src_tready (src_tready),
        .fft_tdata  (fft_tdata),
        .fft_tvalid (fft_tvalid),
        .fft_tready (fft_tready),
        .fft_tlast  (fft_tlast),
        .mag_tdata  (mag_tdata),
        .mag_tvalid (mag_tvalid),
        .mag_tready (mag_tready),
        .bin_tdata  (bin_tdata),
        .bin_index  (bin_index),
        .bin_tvalid (bin_tvalid),
        .bin_tready (bin_tready),
        .bin_tlast  (bin_tlast),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mag_word(input int j);
        return 32'h4120_0000 + 32'(j) * 32'h0000_1357;
    endfunction

    // FFT-side scoreboard.
    always @(negedge aclk) begin
        if (fft_tvalid && fft_tready) begin
            checks++;
            assert (fft_q.size() != 0) else begin
                failures++;
                $error("FAIL fft_unexpected_hs observed=%0h expected=none", fft_tdata);
            end
            if (fft_q.size() != 0) begin
                logic [64:0] e;
                e = fft_q.pop_front();
                chk("fft_tdata", fft_tdata, e[63:0]);
                chk("fft_tlast", 64'(fft_tlast), 64'(e[64]));
            end
        end
    end

    // Bin-side scoreboard, stall stability and frame_done pulse count.
    always @(negedge aclk) begin
        if (held_v && bin_tvalid)
            chk("bin_stall_stable", 64'({bin_tlast, bin_index, bin_tdata}), 64'(held));
        held_v = bin_tvalid && !bin_tready;
        held   = {bin_tlast, bin_index, bin_tdata};
        if (bin_tvalid && bin_tready) begin
            checks++;
            assert (bin_q.size() != 0) else begin
                failures++;
                $error("FAIL bin_unexpected_hs observed=%0h expected=none", bin_tdata);
            end
            if (bin_q.size() != 0)
                chk("bin_word", 64'({bin_tlast, bin_index, bin_tdata}), 64'(bin_q.pop_front()));
        end
        if (frame_done)
            done_pulses++;
    end

    task automatic start_config(input int delay);
        @(posedge aclk); #1 start = 1'b1;
        @(posedge aclk); #1 start = 1'b0;
        for (int k = 0; k <= delay; k++) begin
            cfg_tready = (k == delay);
            @(negedge aclk);
            chk("cfg_tvalid_held", 64'(cfg_tvalid), 64'd1);
            chk("cfg_tdata", 64'(cfg_tdata), 64'h0001);
            @(posedge aclk); #1;
        end
        cfg_tready = 1'b0;
    endtask

    task automatic send_samples(input int n, input bit stall);
        int i   = 0;
        int cyc = 0;
        bit pushed = 1'b0;
        while (i < n && cyc < 200) begin
            src_tvalid = 1'b1;
            src_tdata  = samples[i];
            if (!pushed) begin
                fft_q.push_back({(i == FFT_LEN - 1), 32'h0, samples[i]});
                pushed = 1'b1;
            end
            fft_tready = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
            @(negedge aclk);
            if (fft_tvalid && fft_tready) begin
                i++;
                pushed = 1'b0;
            end
            @(posedge aclk); #1;
            cyc++;
        end
        src_tvalid = 1'b0;
        fft_tready = 1'b0;
        chk("samples_sent", 64'(i), 64'(n));
    endtask

    task automatic run_bins(input int n);
        int j   = 0;
        int cyc = 0;
        bit pushed   = 1'b0;
        bit saw_last = 1'b0;
        while (!saw_last && cyc < 300) begin
            bin_tready = (cyc % 2 == 1);
            if (j < n) begin
                mag_tvalid = 1'b1;
                mag_tdata  = mag_word(j);
                if (!pushed) begin
                    bin_q.push_back({(j == FFT_LEN - 1), 3'(j), mag_word(j)});
                    pushed = 1'b1;
                end
            end else begin
                mag_tvalid = 1'b0;
            end
            @(negedge aclk);
            if (mag_tvalid && mag_tready) begin
                j++;
                pushed = 1'b0;
            end
            if (bin_tvalid && bin_tready && bin_tlast)
                saw_last = 1'b1;
            @(posedge aclk); #1;
            cyc++;
        end
        mag_tvalid = 1'b0;
        bin_tready = 1'b0;
        chk("bins_complete", 64'(saw_last), 64'd1);
    endtask

    task automatic finish_frame(input int exp_pulses);
        @(negedge aclk);
        chk("frame_done_pulse", 64'(frame_done), 64'd1);
        chk("busy_in_done", 64'(busy), 64'd1);
        @(posedge aclk); #1;
        @(negedge aclk);
        chk("frame_done_one_cycle", 64'(frame_done), 64'd0);
        chk("busy_falls", 64'(busy), 64'd0);
        chk("bin_tvalid_after_done", 64'(bin_tvalid), 64'd0);
        chk("done_pulse_count", 64'(done_pulses), 64'(exp_pulses));
        @(posedge aclk); #1;
    endtask

    initial begin
        // Reset values.
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_cfg_tvalid", 64'(cfg_tvalid), 64'd0);
        chk("rst_bin_tvalid", 64'(bin_tvalid), 64'd0);
        chk("rst_bin_tdata", 64'(bin_tdata), 64'd0);
        chk("rst_bin_index", 64'(bin_index), 64'd0);
        chk("rst_bin_tlast", 64'(bin_tlast), 64'd0);
        chk("rst_frame_done", 64'(frame_done), 64'd0);
        chk("rst_fft_tvalid", 64'(fft_tvalid), 64'd0);
        @(posedge aclk); #1 aresetn = 1'b1;

        // mag in IDLE is refused; abort in IDLE does nothing.
        mag_tvalid = 1'b1;
        mag_tdata  = 32'hDEAD_BEEF;
        abort      = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge aclk);
            chk("idle_mag_tready", 64'(mag_tready), 64'd0);
            chk("idle_bin_tvalid", 64'(bin_tvalid), 64'd0);
            chk("idle_abort_busy", 64'(busy), 64'd0);
            @(posedge aclk); #1;
        end
        mag_tvalid = 1'b0;
        abort      = 1'b0;

        // Frame 1: delayed config, stalled load, toggling drain.
        @(posedge aclk); #1 start = 1'b1;
        @(posedge aclk); #1 start = 1'b0;
        mag_tvalid = 1'b1;
        @(negedge aclk);
        chk("config_mag_tready", 64'(mag_tready), 64'd0);
        mag_tvalid = 1'b0;
        for (int k = 0; k <= 3; k++) begin
            cfg_tready = (k == 3);
            @(negedge aclk);
            chk("cfg_tvalid_held", 64'(cfg_tvalid), 64'd1);
            chk("cfg_tdata", 64'(cfg_tdata), 64'h0001);
            @(posedge aclk); #1;
        end
        cfg_tready = 1'b0;
        fft_tready = 1'b1;
        start      = 1'b1;
        @(negedge aclk);
        chk("load_src_tready", 64'(src_tready), 64'd1);
        chk("load_cfg_tvalid", 64'(cfg_tvalid), 64'd0);
        @(posedge aclk); #1 start = 1'b0;
        @(negedge aclk);
        chk("load_start_ignored", 64'(src_tready), 64'd1);
        @(posedge aclk); #1;
        send_samples(8, 1'b1);
        src_tvalid = 1'b1;
        fft_tready = 1'b1;
        start      = 1'b1;
        @(negedge aclk);
        chk("drain_src_tready", 64'(src_tready), 64'd0);
        chk("drain_fft_tvalid", 64'(fft_tvalid), 64'd0);
        chk("drain_fft_tlast", 64'(fft_tlast), 64'd0);
        chk("drain_busy", 64'(busy), 64'd1);
        @(posedge aclk); #1 start = 1'b0;
        @(negedge aclk);
        chk("drain_start_ignored", 64'(cfg_tvalid), 64'd0);
        chk("drain_still_no_src", 64'(src_tready), 64'd0);
        @(posedge aclk); #1;
        src_tvalid = 1'b0;
        fft_tready = 1'b0;
        run_bins(8);
        finish_frame(1);

        // Abort after 5 samples with one bin pending.
        start_config(0);
        send_samples(5, 1'b0);
        mag_tvalid = 1'b1;
        mag_tdata  = 32'h1234_5678;
        bin_q.push_back({1'b0, 3'd0, 32'h1234_5678});
        @(negedge aclk);
        chk("abort_mag_tready", 64'(mag_tready), 64'd1);
        @(posedge aclk); #1 mag_tvalid = 1'b0;
        @(negedge aclk);
        chk("abort_bin_pending", 64'(bin_tvalid), 64'd1);
        @(posedge aclk); #1 abort = 1'b1;
        @(posedge aclk); #1 abort = 1'b0;
        @(negedge aclk);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_bin_tvalid", 64'(bin_tvalid), 64'd0);
        chk("abort_frame_done", 64'(frame_done), 64'd0);
        chk("abort_no_done_pulse", 64'(done_pulses), 64'd1);
        bin_q.delete();
        @(posedge aclk); #1;

        // Clean frame after abort.
        start_config(1);
        send_samples(8, 1'b1);
        run_bins(8);
        finish_frame(2);

        // Reset while draining.
        start_config(0);
        send_samples(8, 1'b0);
        mag_tvalid = 1'b1;
        mag_tdata  = 32'hCAFE_F00D;
        bin_q.push_back({1'b0, 3'd0, 32'hCAFE_F00D});
        @(posedge aclk); #1 mag_tvalid = 1'b0;
        @(negedge aclk);
        chk("drain_bin_before_rst", 64'(bin_tvalid), 64'd1);
        @(posedge aclk); #2 aresetn = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_bin_tvalid", 64'(bin_tvalid), 64'd0);
        chk("arst_bin_tdata", 64'(bin_tdata), 64'd0);
        chk("arst_bin_index", 64'(bin_index), 64'd0);
        chk("arst_bin_tlast", 64'(bin_tlast), 64'd0);
        chk("arst_cfg_tvalid", 64'(cfg_tvalid), 64'd0);
        chk("arst_frame_done", 64'(frame_done), 64'd0);
        bin_q.delete();
        @(posedge aclk); #1 aresetn = 1'b1;

        // First frame after reset starts clean.
        start_config(0);
        send_samples(8, 1'b0);
        run_bins(8);
        finish_frame(3);

        chk("fft_q_drained", 64'(fft_q.size()), 64'd0);
        chk("bin_q_drained", 64'(bin_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
